// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero completes on the accepting edge with an all-ones quotient and dbz set.
module seq_restoring_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic          dbz,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [VW:0]   r_q, t, r_next;
    logic [DW-1:0] sh_q;
    logic [VW-1:0] dv_q;
    logic [CW-1:0] cnt_q;
    logic          q_bit;
    logic          accept;
    logic          last_step;

    assign accept    = start && (state_q != BUSY);
    assign last_step = (state_q == BUSY) && (cnt_q == CW'(1));

    // Dividend bits leave the MSB of sh_q while quotient bits enter at its LSB.
    always_comb begin
        t      = {r_q[VW-1:0], sh_q[DW-1]};
        q_bit  = (t >= {1'b0, dv_q});
        r_next = q_bit ? (t - {1'b0, dv_q}) : t;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == BUSY);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            sh_q      <= '0;
            dv_q      <= '0;
            cnt_q     <= '0;
            dbz       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            if (divisor != '0) begin
                dv_q  <= divisor;
                r_q   <= '0;
                sh_q  <= dividend;
                cnt_q <= CW'(DW);
                dbz   <= 1'b0;
            end else begin
                dbz       <= 1'b1;
                quotient  <= '1;
                remainder <= '0;
            end
        end else if (state_q == BUSY) begin
            r_q   <= r_next;
            sh_q  <= {sh_q[DW-2:0], q_bit};
            cnt_q <= cnt_q - CW'(1);
            if (last_step) begin
                quotient  <= {sh_q[DW-2:0], q_bit};
                remainder <= r_next[VW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed steps plus an exhaustive sweep,
// with expected results queued at stimulus time and compared when done rises.
module tb_seq_restoring_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy, done, dbz;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;

    typedef struct {
        int dd;
        int dv;
        int q;
        int r;
        int z;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int dd, input int dv);
        exp_t e;
        logic [DW-1:0] dd_v;
        logic [VW-1:0] dv_v;
        dd_v = dd[DW-1:0];
        dv_v = dv[VW-1:0];
        @(negedge clk);
        dividend = dd_v;
        divisor  = dv_v;
        start    = 1'b1;
        e.dd = dd;
        e.dv = dv;
        if (dv == 0) begin
            e.q = (1 << DW) - 1;
            e.r = 0;
            e.z = 1;
        end else begin
            e.q = dd / dv;
            e.r = dd % dv;
            e.z = 0;
        end
        sb.push_back(e);
    endtask

    // cyc counts edges after the accepting edge; bn counts samples with busy high.
    task automatic collect(input int cyc0, input int bn0, input int exp_lat, input string tag);
        int   cyc;
        int   bn;
        exp_t e;
        cyc = cyc0;
        bn  = bn0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) bn++;
        end
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_busy_cycles"}, bn, exp_lat);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_quotient"}, quotient, e.q);
            check({tag, "_remainder"}, remainder, e.r);
            check({tag, "_dbz"}, dbz, e.z);
            if (e.z == 0) begin
                check({tag, "_product"}, int'(quotient) * e.dv + int'(remainder), e.dd);
                check({tag, "_rem_lt_div"}, int'(remainder) < e.dv, 1);
            end
        end
    endtask

    task automatic do_op(input int dd, input int dv, input string tag);
        int bn;
        drive(dd, dv);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_after_accept"}, done, (dv == 0) ? 1 : 0);
        bn = busy ? 1 : 0;
        collect(0, bn, (dv == 0) ? 0 : DW, tag);
    endtask

    initial begin
        int bn;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_dbz", dbz, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(200, 7, "d200_7");
        do_op(255, 1, "d255_1");
        do_op(0, 9, "d0_9");
        do_op(15, 15, "d15_15");
        do_op(100, 0, "dbz100");

        // Second start while busy must be ignored.
        drive(200, 7);
        @(negedge clk);
        start = 1'b0;
        bn = busy ? 1 : 0;
        @(negedge clk);
        if (busy) bn++;
        @(negedge clk);
        if (busy) bn++;
        dividend = 8'd50;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        if (busy) bn++;
        start = 1'b0;
        collect(3, bn, DW, "ignore_busy");

        // Back-to-back start while in DONE.
        check("b2b_done_before", done, 1);
        do_op(50, 3, "b2b50_3");

        // Reset mid-operation aborts the division.
        drive(200, 7);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dbz", dbz, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_done", done, 0);
        do_op(99, 10, "d99_10");

        for (int dd = 0; dd < 256; dd++) begin
            for (int dv = 1; dv < 16; dv++) begin
                do_op(dd, dv, "sweep");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
